snake_body_sequencer: RTL

SNAKE_BODY_SEQUENCER -- requirements
Module: snake_body_sequencer

---
 rtl/snake_body_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_body_sequencer.sv
// Snake game body sequencer: moves the snake one cell per tick, handles eating,
// food re-placement through an external PRNG, collisions and the LED bitmap.
module snake_body_sequencer #(
    parameter int          START_LEN = 3,
    parameter logic [5:0]  INIT_FOOD = 6'd29
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        tick,
    input  logic        no_update,
    input  logic [1:0]  direction,
    input  logic [5:0]  prng_value,
    input  logic        prng_valid,
    output logic        prng_req,
    output logic        done,
    output logic        game_end,
    output logic [63:0] led_array_flat,
    output logic [6:0]  length
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STEP     = 3'd1,
        FOOD_REQ = 3'd2,
        FOOD_CHK = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [63:0] INIT_OCC      = ((64'd1 << START_LEN) - 64'd1) << 25;
    localparam logic [5:0]  INIT_HEAD     = 6'(24 + START_LEN);
    localparam logic [5:0]  INIT_HEAD_PTR = 6'(START_LEN - 1);

    state_t      state;
    state_t      state_next;

    logic [5:0]  body_mem [64];
    logic [5:0]  head_ptr;
    logic [5:0]  tail_ptr;
    logic [5:0]  head_pos;
    logic [5:0]  tail_pos;
    logic [5:0]  food;
    logic [5:0]  cand;
    logic [63:0] occ;
    logic        blink;
    logic [1:0]  dir_latch;
    logic [3:0]  seed_valid;

    logic [5:0]  next_pos;
    logic [5:0]  wr_addr;
    logic        eat;
    logic        collide;
    logic        mem_we;

    function automatic logic [5:0] step_pos(input logic [5:0] p, input logic [1:0] d);
        logic [2:0] r;
        logic [2:0] c;
        r = p[5:3];
        c = p[2:0];
        case (d)
            2'd0:    r = r + 3'd1;
            2'd1:    r = r - 3'd1;
            2'd2:    c = c - 3'd1;
            default: c = c + 3'd1;
        endcase
        return {r, c};
    endfunction

    assign next_pos = step_pos(head_pos, dir_latch);
    assign eat      = (next_pos == food);
    // Moving into the tail cell is legal only when the tail is about to vacate it.
    assign collide  = occ[next_pos] && !((next_pos == tail_pos) && !eat);
    assign wr_addr  = head_ptr + 6'd1;
    assign mem_we   = (state == STEP) && !collide;

    // Buffer slots 0..3 hold the reset body until the head first overwrites them.
    always_comb begin
        if ((tail_ptr < 6'd4) && seed_valid[tail_ptr[1:0]]) begin
            tail_pos = 6'd25 + tail_ptr;
        end else begin
            tail_pos = body_mem[tail_ptr];
        end
    end

    always_ff @(posedge clka) begin
        if (mem_we) begin
            body_mem[wr_addr] <= next_pos;
        end
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = (no_update || game_end) ? DONE : STEP;
                end
            end
            STEP: begin
                if (collide) begin
                    state_next = DONE;
                end else if (eat && (length != 7'd63)) begin
                    state_next = FOOD_REQ;
                end else begin
                    state_next = DONE;
                end
            end
            FOOD_REQ: begin
                if (prng_valid) begin
                    state_next = FOOD_CHK;
                end
            end
            FOOD_CHK: state_next = occ[cand] ? FOOD_REQ : DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        done     = (state == DONE);
        prng_req = (state == FOOD_REQ);
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            head_ptr   <= INIT_HEAD_PTR;
            tail_ptr   <= 6'd0;
            head_pos   <= INIT_HEAD;
            food       <= INIT_FOOD;
            cand       <= 6'd0;
            occ        <= INIT_OCC;
            blink      <= 1'b0;
            dir_latch  <= 2'd3;
            seed_valid <= 4'hF;
            game_end   <= 1'b0;
            length     <= 7'(START_LEN);
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        if (no_update) begin
                            blink <= ~blink;
                        end else begin
                            blink     <= 1'b0;
                            dir_latch <= direction;
                        end
                    end
                end
                STEP: begin
                    if (collide) begin
                        game_end <= 1'b1;
                    end else begin
                        // Tail clear precedes head set so a tail-chase leaves the cell lit.
                        if (!eat) begin
                            occ[tail_pos] <= 1'b0;
                            tail_ptr      <= tail_ptr + 6'd1;
                        end else begin
                            length <= length + 7'd1;
                            if (length == 7'd63) begin
                                game_end <= 1'b1;
                            end
                        end
                        occ[next_pos] <= 1'b1;
                        head_ptr      <= wr_addr;
                        head_pos      <= next_pos;
                        if (wr_addr < 6'd4) begin
                            seed_valid[wr_addr[1:0]] <= 1'b0;
                        end
                    end
                end
                FOOD_REQ: begin
                    if (prng_valid) begin
                        cand <= prng_value;
                    end
                end
                FOOD_CHK: begin
                    if (!occ[cand]) begin
                        food <= cand;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        led_array_flat       = occ;
        led_array_flat[food] = 1'b1;
        if (blink) begin
            led_array_flat[head_pos] = 1'b0;
        end
    end

endmodule
